subtrator_serial: RTL and testbench
===================================

Name: subtrator_serial

Overview:
- Bit-serial, LSB-first unsigned/two's-complement subtractor: D = A - B - Bin.
- Inverse arithmetic function of the team's full-adder cell; reuses the same ripple-cell idea but time-multiplexes one 1-bit full-subtractor cell over WIDTH clock cycles.
- Sits in the arithmetic datapath library as a low-area subtract unit. Interface is start/busy/done.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- A  input  WIDTH  minuend. Captured on the accepting edge.
- B  input  WIDTH  subtrahend. Captured on the accepting edge.
- Bin  input  1  borrow-in. Captured on the accepting edge.
- D  output  WIDTH  difference. Registered; holds until the next completion.
- Bout  output  1  final borrow. Equals 1 when A < B + Bin (unsigned).
- Ovf  output  1  signed overflow flag.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - D, Bout, Ovf, busy and done all go to 0 immediately.
  - Internal shift registers, borrow register and counter clear.
  - Reset mid-operation aborts the operation. No partial result appears.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: load sa<=A, sb<=B, br<=Bin, cnt<=0, then go to CALC.
- CALC (busy=1), on each edge, with a=sa[0], b=sb[0]:
  - diff = a^b^br
  - br <= (~a&b) | (~(a^b)&br)
  - sa and sb shift right.
  - The result shift register shifts right, with diff entering at the MSB.
  - cnt increments.
  - On the edge where cnt==WIDTH-1:
    - D <= the completed result.
    - Bout <= the new borrow.
    - Ovf <= (a != b) && (diff != a), where a and b are the operand MSBs and diff is the result MSB.
    - Go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Start is accepted at edge 0.
  - D, Bout and Ovf are valid, and done=1, after edge WIDTH.
  - The next start can be accepted at edge WIDTH+2, giving one op per WIDTH+2 cycles.
- start is ignored in CALC and DONE. Operands are not recaptured.
- A, B and Bin may change freely after the accepting edge.
- D, Bout and Ovf change only on the completion edge (or on reset). They hold stable in IDLE.
- Counter width is clog2(WIDTH).
- Wrap-around is modulo 2^WIDTH. Bout reports the borrow.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2. The unused code 2'd3 recovers to IDLE.
  - Counter-width helper function (clog2).
- One natural sub-module, subtrator_1bit:
  - Combinational full-subtractor cell with inputs a, b, bi and outputs d, bo.
  - Built structurally from gate primitives.
  - Instantiated once inside the serial datapath.

Test Plan (WIDTH=8):
- A=0x2A, B=0x0F, Bin=0, start pulse -> done exactly 8 edges after acceptance; D=0x1B, Bout=0, Ovf=0; busy high for 9 cycles.
- A=0x05, B=0x07, Bin=0 -> D=0xFE, Bout=1, Ovf=0. Then A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1.
- A=0x80, B=0x01 -> D=0x7F, Bout=0, Ovf=1. A=0x7F, B=0xFF -> D=0x80, Bout=1, Ovf=1.
- Back-to-back/ignored start:
  - Hold start=1 continuously while changing A and B each cycle.
  - Required: first op uses the operands from acceptance only; next acceptance occurs at edge 10.
  - Required: no done pulse is missing or extra.
- Reset mid-op:
  - Assert rst_n=0 asynchronously (between edges) during CALC, after bit 4.
  - Required: D, Bout, Ovf, busy and done read 0 before the next edge.
  - Required: after release, A=0x10, B=0x00, Bin=1 gives D=0x0F, Bout=0.
- Exhaustive random sweep:
  - 1000 random A, B, Bin compared against a reference of {Bout,D} = A - B - Bin (WIDTH+1 bits) and the signed overflow rule.
  - Required: every completion matches and done pulses exactly once per accepted start.

Source files
------------

// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the counter-width helper.
package subtrator_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0 .. v-1 (ceil(log2(v))).
  function automatic int cnt_width(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Request/result bundle of the serial subtractor. The master issues start
// with operands; the slave returns the difference, flags and status.
interface subtrator_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  D, Bout, Ovf, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output D, Bout, Ovf, busy, done
  );
endinterface

// File: rtl/subtrator_1bit.sv
// One-bit full subtractor cell: d = a ^ b ^ bi, borrow out when
// a < b + bi. Gate-level so it maps directly onto the cell library.
module subtrator_1bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic axb;
  logic na;
  logic nxor;
  logic g_brw;
  logic p_brw;

  xor x_ab   (axb, a, b);
  xor x_d    (d, axb, bi);
  not n_a    (na, a);
  and a_g    (g_brw, na, b);
  not n_x    (nxor, axb);
  and a_p    (p_brw, nxor, bi);
  or  o_bo   (bo, g_brw, p_brw);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial LSB-first subtractor D = A - B - Bin. A single full-subtractor
// cell is reused over WIDTH cycles; the operation is framed by start/busy/done.
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  subtrator_serial_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a_bit;
  logic b_bit;
  logic diff;
  logic br_nxt;

  assign a_bit = sa[0];
  assign b_bit = sb[0];

  subtrator_1bit u_cell (
    .a  (a_bit),
    .b  (b_bit),
    .bi (br),
    .d  (diff),
    .bo (br_nxt)
  );

  // Control FSM and serial datapath; results and status are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.D    <= '0;
      bus.Bout <= 1'b0;
      bus.Ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sa       <= bus.A;
            sb       <= bus.B;
            br       <= bus.Bin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        CALC: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          res <= {diff, res[WIDTH-1:1]};
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // Last bit: a_bit/b_bit are the operand MSBs, diff the result MSB.
          if (cnt == CW'(WIDTH - 1)) begin
            bus.D    <= {diff, res[WIDTH-1:1]};
            bus.Bout <= br_nxt;
            bus.Ovf  <= (a_bit != b_bit) && (diff != a_bit);
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=8.
module tb_subtrator_serial;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  subtrator_serial_if #(.WIDTH(8)) bus ();

  subtrator_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, bout, d} for a - b - bin using wide arithmetic.
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    logic       ovf;
    r   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    ovf = (a[7] != b[7]) && (r[7] != a[7]);
    return {ovf, r};
  endfunction

  // Issue one operation from IDLE and follow it until busy drops.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int ndone, output int nbusy);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.Bin = ~bin;
    lat = -1; ndone = 0; nbusy = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, nd, nb;
    int d_edge0, d_edge1, ndn;
    logic [7:0] d0, d1, a_e, b_e;
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic       rbin;

    errs = 0; checks = 0;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_D", bus.D, 0);
    check("rst_flags", {bus.Bout, bus.Ovf, bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic operation with latency and busy length.
    run_op(8'h2A, 8'h0F, 1'b0, lat, nd, nb);
    check("t1_lat", lat, 8);
    check("t1_busy_cycles", nb, 9);
    check("t1_ndone", nd, 1);
    check("t1_D", bus.D, 8'h1B);
    check("t1_Bout", bus.Bout, 0);
    check("t1_Ovf", bus.Ovf, 0);

    // Result holds in IDLE while inputs wander.
    for (int i = 0; i < 3; i++) begin
      bus.A = 8'(i * 91); bus.B = 8'(i * 17 + 3);
      @(posedge clk); #1;
    end
    check("hold_D", bus.D, 8'h1B);
    check("hold_busy", bus.busy, 0);

    run_op(8'h05, 8'h07, 1'b0, lat, nd, nb);
    check("t2_D", bus.D, 8'hFE);
    check("t2_BoutOvf", {bus.Bout, bus.Ovf}, 2'b10);

    run_op(8'h00, 8'h00, 1'b1, lat, nd, nb);
    check("t3_D", bus.D, 8'hFF);
    check("t3_BoutOvf", {bus.Bout, bus.Ovf}, 2'b10);

    run_op(8'h80, 8'h01, 1'b0, lat, nd, nb);
    check("t4_D", bus.D, 8'h7F);
    check("t4_BoutOvf", {bus.Bout, bus.Ovf}, 2'b01);

    run_op(8'h7F, 8'hFF, 1'b0, lat, nd, nb);
    check("t5_D", bus.D, 8'h80);
    check("t5_BoutOvf", {bus.Bout, bus.Ovf}, 2'b11);

    // start held high, operands changing every cycle.
    d_edge0 = -1; d_edge1 = -1; ndn = 0; d0 = '0; d1 = '0;
    bus.start = 1'b1; bus.Bin = 1'b0;
    for (int e = 0; e < 22; e++) begin
      bus.A = 8'(e * 37 + 5);
      bus.B = 8'(e * 13 + 1);
      @(posedge clk); #1;
      if (bus.done) begin
        ndn++;
        if (d_edge0 < 0) begin d_edge0 = e; d0 = bus.D; end
        else if (d_edge1 < 0) begin d_edge1 = e; d1 = bus.D; end
      end
    end
    bus.start = 1'b0;
    check("b2b_ndone", ndn, 2);
    check("b2b_edge0", d_edge0, 8);
    check("b2b_edge1", d_edge1, 18);
    a_e = 8'(0 * 37 + 5); b_e = 8'(0 * 13 + 1);
    r = ref_sub(a_e, b_e, 1'b0);
    check("b2b_D0", d0, r[7:0]);
    a_e = 8'(10 * 37 + 5); b_e = 8'(10 * 13 + 1);
    r = ref_sub(a_e, b_e, 1'b0);
    check("b2b_D1", d1, r[7:0]);
    for (int n = 0; n < 20 && bus.busy; n++) begin
      @(posedge clk); #1;
    end
    check("b2b_idle", bus.busy, 0);

    // Asynchronous reset in the middle of CALC.
    run_op(8'h33, 8'h11, 1'b0, lat, nd, nb);
    check("pre_rst_D", bus.D, 8'h22);
    bus.A = 8'h2A; bus.B = 8'h0F; bus.Bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_D", bus.D, 0);
    check("mid_rst_flags", {bus.Bout, bus.Ovf, bus.busy, bus.done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", bus.busy, 0);
    run_op(8'h10, 8'h00, 1'b1, lat, nd, nb);
    check("post_rst_D", bus.D, 8'h0F);
    check("post_rst_Bout", bus.Bout, 0);
    check("post_rst_lat", lat, 8);

    // Random sweep against the wide-arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      r = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, lat, nd, nb);
      check($sformatf("rnd%0d_D", i), bus.D, r[7:0]);
      check($sformatf("rnd%0d_BoutOvf", i), {bus.Bout, bus.Ovf}, {r[8], r[9]});
      check($sformatf("rnd%0d_ndone", i), nd, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
